// File: rtl/display_pager.sv
// Multi-page 7-segment display controller: manual/auto page selection, per-digit
// blink and leading-zero blanking, producing registered active-low segment codes.
module display_pager #(
    parameter int N_DIG      = 8,
    parameter int N_PAGES    = 2,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int AUTO_DWELL = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PAGES*N_DIG*4-1:0] page_data,
    input  logic [N_PAGES*N_DIG-1:0]   blink_en,
    input  logic                       tick_1hz,
    input  logic                       mode_auto,
    input  logic [2:0]                 page_sel,
    input  logic                       page_next,
    input  logic                       lzb_en,
    output logic [N_DIG*7-1:0]         hex,
    output logic [2:0]                 cur_page,
    output logic                       blink_phase
);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DW = $clog2(AUTO_DWELL + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_DWELL - 1);
    localparam logic [2:0]    LAST_PAGE  = 3'(N_PAGES - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           cur_page_reg, cur_page_next;
    logic [DW-1:0]        dwell_reg, dwell_next;
    logic [BW-1:0]        blink_cnt_reg;
    logic                 phase_reg;
    logic [N_DIG*7-1:0]   hex_reg, hex_next;

    // Pages padded to 8 entries so the 3-bit page index always addresses the array fully.
    logic [N_DIG*4-1:0]   page_words  [8];
    logic [N_DIG-1:0]     blink_words [8];
    logic [N_DIG*4-1:0]   cur_digits;
    logic [N_DIG-1:0]     cur_blink;
    logic                 edit_hold;
    logic [2:0]           page_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_page
            if (gi < N_PAGES) begin : g_used
                assign page_words[gi]  = page_data[gi*N_DIG*4 +: N_DIG*4];
                assign blink_words[gi] = blink_en[gi*N_DIG +: N_DIG];
            end else begin : g_unused
                assign page_words[gi]  = '0;
                assign blink_words[gi] = '0;
            end
        end
    endgenerate

    assign cur_digits = page_words[cur_page_reg];
    assign cur_blink  = blink_words[cur_page_reg];
    assign edit_hold  = |cur_blink;
    assign page_inc   = (cur_page_reg == LAST_PAGE) ? 3'd0 : cur_page_reg + 3'd1;

    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Entering AUTO keeps the current page, so page_sel is only honoured while staying in MANUAL.
    always_comb begin
        state_next    = state_reg;
        cur_page_next = cur_page_reg;
        dwell_next    = dwell_reg;
        case (state_reg)
            MANUAL: begin
                if (mode_auto) begin
                    state_next = AUTO;
                    dwell_next = '0;
                end else if ({1'b0, page_sel} < 4'(N_PAGES)) begin
                    cur_page_next = page_sel;
                end
            end
            AUTO: begin
                if (!mode_auto)
                    state_next = MANUAL;
                if (page_next) begin
                    cur_page_next = page_inc;
                    dwell_next    = '0;
                end else if (tick_1hz && !edit_hold) begin
                    if (dwell_reg == DWELL_LAST) begin
                        cur_page_next = page_inc;
                        dwell_next    = '0;
                    end else begin
                        dwell_next = dwell_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    logic       zero_run;
    logic       blank;
    logic [3:0] code;

    always_comb begin
        hex_next = '0;
        zero_run = 1'b1;
        blank    = 1'b0;
        code     = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            code     = cur_digits[i*4 +: 4];
            zero_run = zero_run & (code == 4'd0);
            blank    = (cur_blink[i] & ~phase_reg) | (lzb_en & zero_run & (i != 0));
            hex_next[i*7 +: 7] = blank ? 7'h7F : seg7(code);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= MANUAL;
            cur_page_reg  <= '0;
            dwell_reg     <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b1;
            hex_reg       <= {N_DIG{7'h7F}};
        end else begin
            state_reg    <= state_next;
            cur_page_reg <= cur_page_next;
            dwell_reg    <= dwell_next;
            hex_reg      <= hex_next;
            // A freshly selected page restarts the blink cycle in its visible half.
            if (cur_page_next != cur_page_reg) begin
                blink_cnt_reg <= '0;
                phase_reg     <= 1'b1;
            end else if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign hex         = hex_reg;
    assign cur_page    = cur_page_reg;
    assign blink_phase = phase_reg;
endmodule

// File: tb/tb_display_pager.sv
// Directed scenarios plus randomized traffic for display_pager, checked every cycle
// against a cycle-level behavioural model of the display rules.
module tb_display_pager;
    localparam int ND = 8;
    localparam int NP = 2;
    localparam int BD = 4;
    localparam int AD = 3;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP*ND*4-1:0] page_data;
    logic [NP*ND-1:0]   blink_en;
    logic               tick_1hz, mode_auto, page_next, lzb_en;
    logic [2:0]         page_sel;
    logic [ND*7-1:0]    hex;
    logic [2:0]         cur_page;
    logic               blink_phase;

    int n_vec = 0;
    int n_err = 0;

    display_pager #(.N_DIG(ND), .N_PAGES(NP), .BLINK_DIV(BD), .AUTO_DWELL(AD)) dut (
        .clk(clk), .rst_n(rst_n), .page_data(page_data), .blink_en(blink_en),
        .tick_1hz(tick_1hz), .mode_auto(mode_auto), .page_sel(page_sel),
        .page_next(page_next), .lzb_en(lzb_en), .hex(hex), .cur_page(cur_page),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit              m_auto;
    int              m_page, m_dwell, m_bcnt;
    bit              m_phase;
    logic [ND*7-1:0] m_hex;

    function automatic int digit_of(int p, int d);
        return int'((page_data >> ((p * ND + d) * 4)) & 64'hF);
    endfunction

    function automatic logic [6:0] shown(int p, int d);
        int  c;
        bit  all_zero_above;
        c = digit_of(p, d);
        if (blink_en[p * ND + d] && !m_phase) return 7'h7F;
        all_zero_above = 1'b1;
        for (int j = d; j < ND; j++)
            if (digit_of(p, j) != 0) all_zero_above = 1'b0;
        if (lzb_en && d != 0 && all_zero_above) return 7'h7F;
        if (c > 9) return 7'h7F;
        return SEG_TAB[c];
    endfunction

    always @(posedge clk) begin
        int  new_page;
        bit  frozen;
        if (!rst_n) begin
            m_auto = 0; m_page = 0; m_dwell = 0; m_bcnt = 0; m_phase = 1;
            m_hex  = {ND{7'h7F}};
        end else begin
            for (int d = 0; d < ND; d++) m_hex[d*7 +: 7] = shown(m_page, d);
            new_page = m_page;
            if (!m_auto) begin
                if (mode_auto) begin
                    m_auto  = 1;
                    m_dwell = 0;
                end else if (int'(page_sel) < NP) begin
                    new_page = int'(page_sel);
                end
            end else begin
                if (!mode_auto) m_auto = 0;
                frozen = 0;
                for (int d = 0; d < ND; d++) if (blink_en[m_page * ND + d]) frozen = 1;
                if (page_next) begin
                    new_page = (m_page + 1) % NP;
                    m_dwell  = 0;
                end else if (tick_1hz && !frozen) begin
                    m_dwell++;
                    if (m_dwell == AD) begin
                        new_page = (m_page + 1) % NP;
                        m_dwell  = 0;
                    end
                end
            end
            if (new_page != m_page) begin
                m_bcnt = 0; m_phase = 1;
            end else if (m_bcnt == BD - 1) begin
                m_bcnt = 0; m_phase = !m_phase;
            end else begin
                m_bcnt++;
            end
            m_page = new_page;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("model_hex", 64'(hex), 64'(m_hex));
            check("model_page", 64'(cur_page), 64'(m_page));
            check("model_phase", 64'(blink_phase), 64'(m_phase));
        end
    endtask

    initial begin
        int blank_cnt, steady_cnt;
        logic [ND*7-1:0] all_blank;
        all_blank = {ND{7'h7F}};
        rst_n = 0; page_data = '1; blink_en = '0; tick_1hz = 0; mode_auto = 0;
        page_sel = 0; page_next = 0; lzb_en = 0;
        step(2);
        check("rst_hex", 64'(hex), 64'(all_blank));
        check("rst_page", 64'(cur_page), 64'd0);
        check("rst_phase", 64'(blink_phase), 64'd1);
        rst_n = 1;
        $display("reset: hex=%h page=%0d phase=%0d", hex, cur_page, blink_phase);

        page_data[31:0] = 32'hFF123456;
        step(1);
        check("s032_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
        $display("clock 12:34:56: hex=%h", hex);

        page_data[31:0] = 32'h00000105; lzb_en = 1;
        step(1);
        check("s033_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}));
        $display("lzb 00000105: hex=%h", hex);

        page_data[31:0] = 32'hFF123456; lzb_en = 0; blink_en[1:0] = 2'b11;
        blank_cnt = 0; steady_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (hex[6:0] == 7'h7F) blank_cnt++;
            if (hex[20:14] == 7'h19) steady_cnt++;
        end
        check("s034_blank_cycles", 64'(blank_cnt), 64'd8);
        check("s034_steady_digit2", 64'(steady_cnt), 64'd16);
        $display("blink: %0d of 16 cycles blank", blank_cnt);

        blink_en = '0; mode_auto = 1;
        step(1);
        for (int k = 1; k <= 6; k++) begin
            tick_1hz = 1; step(1); tick_1hz = 0;
            if (k == 3) begin
                check("s035_page_after3", 64'(cur_page), 64'd1);
                check("s035_phase_after3", 64'(blink_phase), 64'd1);
            end
            if (k == 6) begin
                check("s035_page_after6", 64'(cur_page), 64'd0);
                check("s035_phase_after6", 64'(blink_phase), 64'd1);
            end
            step(2);
        end
        $display("auto dwell: page=%0d after 6 ticks", cur_page);

        blink_en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick_1hz = 1; step(1); tick_1hz = 0; step(1);
        end
        check("s036_frozen_page", 64'(cur_page), 64'd0);
        page_next = 1; step(1); page_next = 0;
        check("s036_next_page", 64'(cur_page), 64'd1);
        $display("edit hold: page_next -> page=%0d", cur_page);

        blink_en = '0; mode_auto = 0; page_sel = 3'd5;
        step(4);
        check("s037_hold_page", 64'(cur_page), 64'd1);
        step(2);
        rst_n = 0; step(1);
        check("s037_rst_page", 64'(cur_page), 64'd0);
        check("s037_rst_phase", 64'(blink_phase), 64'd1);
        check("s037_rst_hex", 64'(hex), 64'(all_blank));
        rst_n = 1;
        $display("mid-blink reset: page=%0d phase=%0d hex=%h", cur_page, blink_phase, hex);

        for (int c = 0; c < 3000; c++) begin
            if (c % 8 == 0) begin
                for (int n = 0; n < NP * ND; n++)
                    page_data[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                blink_en = ($urandom_range(0, 3) == 0) ? (NP*ND)'($urandom) : '0;
                lzb_en   = 1'($urandom);
            end
            tick_1hz  = ($urandom_range(0, 2) == 0);
            page_next = ($urandom_range(0, 19) == 0);
            page_sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
            rst_n     = ($urandom_range(0, 199) != 0);
            step(1);
        end
        $display("random phase: 3000 cycles done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/display_pager.md
DISPLAY_PAGER -- requirements
Module: display_pager

Interface
REQ-001 SHALL have parameter N_DIG, default 8: digits per page, range 1..8.
REQ-002 SHALL have parameter N_PAGES, default 2: number of display pages, range 2..8.
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period, ≥1.
REQ-004 SHALL have parameter AUTO_DWELL, default 5: tick_1hz pulses per page in auto mode, ≥1.
REQ-005 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port page_data  in  N_PAGES*N_DIG*4  BCD digits. Page p, digit d is at [(p*N_DIG+d)*4 +: 4]. Digit 0 is rightmost. Codes 10..15 mean blank.
REQ-008 SHALL have port blink_en  in  N_PAGES*N_DIG  per-digit blink mask, same indexing as page_data.
REQ-009 SHALL have port tick_1hz  in  1  one-cycle strobe.
REQ-010 SHALL have port mode_auto  in  1  mode select: 1 = auto page cycling, 0 = manual.
REQ-011 SHALL have port page_sel  in  3  manual page index.
REQ-012 SHALL have port page_next  in  1  one-cycle strobe that advances the page in auto mode.
REQ-013 SHALL have port lzb_en  in  1  leading-zero blanking enable.
REQ-014 SHALL have port hex  out  N_DIG*7  registered active-low segments. Digit d is at [d*7 +: 7], bit order gfedcba.
REQ-015 SHALL have port cur_page  out  3  registered index of the displayed page.
REQ-016 SHALL have port blink_phase  out  1  registered blink phase: 1 = visible half, 0 = blanked half.

Function
REQ-017 SHALL encode digits as 0..9 = 7'h40,79,24,30,19,12,02,78,00,10; codes 10..15 = 7'h7F (blank).
REQ-018 SHALL register hex one cycle after cur_page, blink_phase, page_data, blink_en and lzb_en; total latency is 1 clk.
REQ-019 SHALL output digit d as blank when blink_en[cur_page][d]=1 and blink_phase=0.
REQ-020 SHALL apply leading-zero blanking when lzb_en=1: each digit from index N_DIG-1 downward SHALL be blanked while it and all higher digits equal 0; digit 0 is never blanked by this rule.
REQ-021 SHALL run a blink counter from 0 to BLINK_DIV-1. On wrap, blink_phase SHALL toggle.
REQ-022 SHALL clear the blink counter and set blink_phase=1 on every change of cur_page, so a newly shown page appears visible first.
REQ-023 SHALL implement FSM states MANUAL and AUTO. mode_auto=1 in MANUAL SHALL move to AUTO next cycle; mode_auto=0 in AUTO SHALL move to MANUAL next cycle.
REQ-024 SHALL, in MANUAL, load cur_page from page_sel when page_sel<N_PAGES; otherwise cur_page holds its value. page_next is ignored in MANUAL.
REQ-025 SHALL, in AUTO, count tick_1hz pulses in a dwell counter. On reaching AUTO_DWELL, cur_page SHALL advance by 1, wrapping N_PAGES-1 to 0, and the dwell counter SHALL clear.
REQ-026 SHALL, in AUTO, advance cur_page immediately on page_next and clear the dwell counter.
REQ-027 SHALL, when page_next and a dwell-completing tick occur in the same cycle, advance cur_page by exactly 1.
REQ-028 SHALL freeze the dwell counter and suppress automatic advance in AUTO while any blink_en bit of cur_page is 1 (edit in progress). page_next still advances.
REQ-029 SHALL, on entry to AUTO, keep cur_page unchanged and clear the dwell counter.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, set FSM=MANUAL, cur_page=0, blink_phase=1, blink counter=0, dwell counter=0, and every hex digit to 7'h7F.
REQ-031 SHALL resume from reset values on the first edge with rst_n=1, with hex valid one cycle later. Reset mid-blink or mid-dwell discards all progress.

Verification
REQ-032 SHALL pass this scenario (N_DIG=8, BLINK_DIV=4): page0 shows 12:34:56 with blanks in digits 7,6, lzb_en=0 -> hex = 7F,7F,79,24,30,19,12,02.
REQ-033 SHALL pass this scenario: page0 digits = 0,0,0,0,0,1,0,5 (MSB first), lzb_en=1 -> digits 7..3 = 7F, digit2=79, digit1=40, digit0=12.
REQ-034 SHALL pass this scenario: blink_en[0][1:0]=11, BLINK_DIV=4 -> digits 1,0 visible 4 cycles, blank 4 cycles, repeating; other digits steady.
REQ-035 SHALL pass this scenario: AUTO, AUTO_DWELL=3, no blink -> cur_page goes 0->1 on the 3rd tick and 1->0 on the 6th; blink_phase=1 right after each change.
REQ-036 SHALL pass this scenario: AUTO with page0 blink bit set -> 10 ticks cause no advance; then page_next -> cur_page=1 next cycle.
REQ-037 SHALL pass this scenario: MANUAL, page_sel=5 with N_PAGES=2 -> cur_page holds; then rst_n=0 for 1 cycle mid-blink -> cur_page=0, blink_phase=1, all hex=7F.
